// File: rtl/gpio_bank.sv
// Multi-port GPIO block: per-port output register with set/clear/toggle aliases,
// synchronized and debounced inputs, and sticky edge-event interrupt flags.
module gpio_bank #(
    parameter int N_PORTS         = 2,
    parameter int PORT_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic                            we,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    input  logic [N_PORTS*PORT_WIDTH-1:0]   gpio_in,
    output logic [N_PORTS*PORT_WIDTH-1:0]   gpio_out,
    output logic                            irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] IDX_OUT     = 3'd0;
    localparam logic [2:0] IDX_SET     = 3'd1;
    localparam logic [2:0] IDX_CLR     = 3'd2;
    localparam logic [2:0] IDX_TGL     = 3'd3;
    localparam logic [2:0] IDX_IN      = 3'd4;
    localparam logic [2:0] IDX_RISE    = 3'd5;
    localparam logic [2:0] IDX_FALL    = 3'd6;
    localparam logic [2:0] IDX_STAT    = 3'd7;

    logic [31:0]           port_sel;
    logic                  port_hit;
    logic [2:0]            reg_idx;
    logic [PORT_WIDTH-1:0] wval;
    logic                  unused_bits;

    logic [PORT_WIDTH-1:0] out_reg   [N_PORTS];
    logic [PORT_WIDTH-1:0] rise_en   [N_PORTS];
    logic [PORT_WIDTH-1:0] fall_en   [N_PORTS];
    logic [PORT_WIDTH-1:0] irq_stat  [N_PORTS];
    logic [PORT_WIDTH-1:0] in_reg    [N_PORTS];
    logic [PORT_WIDTH-1:0] s1        [N_PORTS];
    logic [PORT_WIDTH-1:0] s2        [N_PORTS];
    logic [CW-1:0]         cnt       [N_PORTS][PORT_WIDTH];

    logic [N_PORTS-1:0]    wr_en;
    logic [PORT_WIDTH-1:0] out_next  [N_PORTS];
    logic [PORT_WIDTH-1:0] stat_next [N_PORTS];
    logic [PORT_WIDTH-1:0] upd       [N_PORTS];
    logic [PORT_WIDTH-1:0] evt       [N_PORTS];

    assign port_sel    = 32'(addr[ADDR_WIDTH-1:5]);
    assign port_hit    = port_sel < 32'(N_PORTS);
    assign reg_idx     = addr[4:2];
    assign wval        = wdata[PORT_WIDTH-1:0];
    assign unused_bits = ^{addr[1:0], wdata};

    // An IN bit flips to s2 once s2 has disagreed for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            wr_en[p]    = we && port_hit && (port_sel == 32'(p));
            out_next[p] = out_reg[p];
            upd[p]      = '0;
            if (wr_en[p]) begin
                case (reg_idx)
                    IDX_OUT: out_next[p] = wval;
                    IDX_SET: out_next[p] = out_reg[p] | wval;
                    IDX_CLR: out_next[p] = out_reg[p] & ~wval;
                    IDX_TGL: out_next[p] = out_reg[p] ^ wval;
                    default: out_next[p] = out_reg[p];
                endcase
            end
            for (int b = 0; b < PORT_WIDTH; b++) begin
                upd[p][b] = (s2[p][b] != in_reg[p][b]) && (cnt[p][b] == CNT_LAST);
            end
            evt[p] = upd[p] & ((s2[p] & rise_en[p]) | (~s2[p] & fall_en[p]));
            // Events are OR-ed after the W1C mask so a coincident event survives.
            stat_next[p] = irq_stat[p];
            if (wr_en[p] && (reg_idx == IDX_STAT)) begin
                stat_next[p] = irq_stat[p] & ~wval;
            end
            stat_next[p] = stat_next[p] | evt[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) begin
                out_reg[p]  <= '0;
                rise_en[p]  <= '0;
                fall_en[p]  <= '0;
                irq_stat[p] <= '0;
                in_reg[p]   <= '0;
                s1[p]       <= '0;
                s2[p]       <= '0;
                for (int b = 0; b < PORT_WIDTH; b++) begin
                    cnt[p][b] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                out_reg[p]  <= out_next[p];
                irq_stat[p] <= stat_next[p];
                in_reg[p]   <= in_reg[p] ^ upd[p];
                s1[p]       <= gpio_in[p*PORT_WIDTH +: PORT_WIDTH];
                s2[p]       <= s1[p];
                if (wr_en[p] && (reg_idx == IDX_RISE)) begin
                    rise_en[p] <= wval;
                end
                if (wr_en[p] && (reg_idx == IDX_FALL)) begin
                    fall_en[p] <= wval;
                end
                for (int b = 0; b < PORT_WIDTH; b++) begin
                    if ((s2[p][b] != in_reg[p][b]) && !upd[p][b]) begin
                        cnt[p][b] <= cnt[p][b] + CW'(1);
                    end else begin
                        cnt[p][b] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (port_hit && (port_sel == 32'(p))) begin
                case (reg_idx)
                    IDX_OUT:  rdata = 32'(out_reg[p]);
                    IDX_IN:   rdata = 32'(in_reg[p]);
                    IDX_RISE: rdata = 32'(rise_en[p]);
                    IDX_FALL: rdata = 32'(fall_en[p]);
                    IDX_STAT: rdata = 32'(irq_stat[p]);
                    default:  rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        irq      = 1'b0;
        gpio_out = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            gpio_out[p*PORT_WIDTH +: PORT_WIDTH] = out_reg[p];
            irq = irq | (|irq_stat[p]);
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with default parameters (2 ports x 8 pins,
// 4-cycle debounce); expected values are hand-computed constants.
module tb_gpio_bank;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd;

    logic [7:0] seq_addr [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
    logic [7:0] seq_data [4] = '{8'hA5, 8'h0F, 8'h81, 8'hFF};
    logic [7:0] seq_exp  [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};

    gpio_bank #(
        .N_PORTS(2),
        .PORT_WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .we(we),
        .wdata(wdata),
        .rdata(rdata),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus write: set up on a falling edge, sampled on the following rising edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic readRegister(input logic [7:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    initial begin
        rst     = 1'b1;
        addr    = '0;
        we      = 1'b0;
        wdata   = '0;
        gpio_in = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset gpio_out", 32'(gpio_out), 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        for (int i = 0; i < 16; i++) begin
            readRegister(8'((i / 8) * 32 + (i % 8) * 4), rd);
            checkOutput($sformatf("reset rdata idx%0d", i), rd, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(seq_addr[i], 32'(seq_data[i]));
            checkOutput($sformatf("out seq gpio_out step%0d", i), 32'(gpio_out), 32'(seq_exp[i]));
            readRegister(8'h00, rd);
            checkOutput($sformatf("out seq read step%0d", i), rd, 32'(seq_exp[i]));
        end
        readRegister(8'h04, rd);
        checkOutput("set alias reads zero", rd, 32'h0);
        applyStimulus(8'h00, 32'hFFFF_FFD1);
        readRegister(8'h00, rd);
        checkOutput("wdata upper bits ignored", rd, 32'hD1);

        applyStimulus(8'h14, 32'h01);
        gpio_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        readRegister(8'h10, rd);
        checkOutput("debounce in before edge6", rd, 32'h0);
        checkOutput("debounce irq before edge6", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        readRegister(8'h10, rd);
        checkOutput("debounce in at edge6", rd, 32'h01);
        readRegister(8'h1C, rd);
        checkOutput("rise stat at edge6", rd, 32'h01);
        checkOutput("rise irq at edge6", 32'(irq), 32'h1);
        applyStimulus(8'h1C, 32'h01);
        checkOutput("w1c irq low", 32'(irq), 32'h0);
        readRegister(8'h1C, rd);
        checkOutput("w1c stat cleared", rd, 32'h0);

        applyStimulus(8'h14, 32'h02);
        applyStimulus(8'h18, 32'h02);
        gpio_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (8) @(negedge clk);
        readRegister(8'h10, rd);
        checkOutput("glitch in unchanged", rd, 32'h01);
        readRegister(8'h1C, rd);
        checkOutput("glitch stat zero", rd, 32'h0);
        checkOutput("glitch irq low", 32'(irq), 32'h0);

        gpio_in[15] = 1'b1;
        repeat (8) @(negedge clk);
        readRegister(8'h30, rd);
        checkOutput("port1 in high", rd, 32'h80);
        checkOutput("port1 no enable no irq", 32'(irq), 32'h0);
        applyStimulus(8'h38, 32'h80);
        gpio_in[15] = 1'b0;
        repeat (5) @(posedge clk);
        applyStimulus(8'h3C, 32'h80);
        readRegister(8'h3C, rd);
        checkOutput("event beats w1c stat", rd, 32'h80);
        checkOutput("event beats w1c irq", 32'(irq), 32'h1);
        readRegister(8'h30, rd);
        checkOutput("port1 in fell", rd, 32'h0);
        applyStimulus(8'h38, 32'h00);
        readRegister(8'h3C, rd);
        checkOutput("enable clear keeps stat", rd, 32'h80);
        applyStimulus(8'h3C, 32'h80);
        checkOutput("port1 w1c irq low", 32'(irq), 32'h0);

        applyStimulus(8'h40, 32'h55);
        readRegister(8'h40, rd);
        checkOutput("port2 read zero", rd, 32'h0);
        checkOutput("port2 gpio_out unchanged", 32'(gpio_out), 32'h00D1);
        checkOutput("port2 irq unchanged", 32'(irq), 32'h0);

        applyStimulus(8'h00, 32'hFF);
        applyStimulus(8'h14, 32'h04);
        gpio_in[2] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("pre-reset irq high", 32'(irq), 32'h1);
        checkOutput("pre-reset gpio_out", 32'(gpio_out), 32'h00FF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset gpio_out", 32'(gpio_out), 32'h0);
        checkOutput("async reset irq", 32'(irq), 32'h0);
        readRegister(8'h10, rd);
        checkOutput("async reset in", rd, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        readRegister(8'h10, rd);
        checkOutput("post-reset in before edge6", rd, 32'h0);
        @(posedge clk);
        #1;
        readRegister(8'h10, rd);
        checkOutput("post-reset in at edge6", rd, 32'h05);
        checkOutput("post-reset irq low", 32'(irq), 32'h0);
        readRegister(8'h14, rd);
        checkOutput("post-reset rise_en zero", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
